// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared state encoding and defaults for the conversion scheduler
package conv_sched_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int MIN_PERIOD_DEF = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_FIRE   = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    FIRE   = ST_FIRE,
    WAIT   = ST_WAIT,
    DRAIN  = ST_DRAIN
  } state_t;

endpackage

// File: rtl/conv_sched_timer.sv
// rtl/conv_sched_timer.sv - loadable down-counter with zero flag; holds at zero
module conv_sched_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/conv_scheduler.sv
// rtl/conv_scheduler.sv - burst ADC conversion run controller (AMP_EN, settle, periodic SEQ_START)
// Optional FIFO back-pressure hold enabled by defining CONV_SCHED_FIFO_HOLD_EN.
module conv_scheduler
  import conv_sched_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic             BUS_CLK,
  input  logic             BUS_RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] CFG_NUM_CONV,
  input  logic [CNT_W-1:0] CFG_PERIOD,
  input  logic [CNT_W-1:0] CFG_SETTLE,
  input  logic             SEQ_BUSY,
  input  logic             FIFO_FULL,
  output logic             SEQ_START,
  output logic             AMP_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] CONV_CNT,
  output logic [CNT_W-1:0] OVERRUN_CNT
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

  state_t           state, next_state;
  logic [CNT_W-1:0] num_sh, per_sh, per_reload;
  logic             accept, ovr_hit, done_next, hold;
  logic             s_load, s_en, s_zero;
  logic             p_load, p_en, p_zero;

  // Period timer is loaded as FIRE is entered, so it reads P-1 during FIRE itself.
  assign per_reload = (per_sh < MIN_P) ? (MIN_P - ONE) : (per_sh - ONE);

`ifdef CONV_SCHED_FIFO_HOLD_EN
  assign hold = FIFO_FULL;
`else
  assign hold = FIFO_FULL & 1'b0;
`endif

  conv_sched_timer #(.W(CNT_W)) u_settle_timer (
    .clk(BUS_CLK), .rst(BUS_RST), .load(s_load), .en(s_en),
    .value(CFG_SETTLE), .zero(s_zero)
  );

  conv_sched_timer #(.W(CNT_W)) u_period_timer (
    .clk(BUS_CLK), .rst(BUS_RST), .load(p_load), .en(p_en),
    .value(per_reload), .zero(p_zero)
  );

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    s_load     = 1'b0;
    s_en       = 1'b0;
    p_load     = 1'b0;
    p_en       = 1'b0;
    ovr_hit    = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (START && !ABORT) begin
          accept     = 1'b1;
          s_load     = 1'b1;
          next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (ABORT) begin
          next_state = DRAIN;
        end else if (s_zero) begin
          p_load     = 1'b1;
          next_state = FIRE;
        end else begin
          s_en = 1'b1;
        end
      end
      FIRE: begin
        p_en = 1'b1;
        if (ABORT || (num_sh != '0 && CONV_CNT == num_sh)) begin
          next_state = DRAIN;
        end else begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (ABORT) begin
          next_state = DRAIN;
        end else if (!p_zero) begin
          p_en = 1'b1;
        end else if (hold) begin
          next_state = WAIT;
        end else if (SEQ_BUSY) begin
          ovr_hit = 1'b1;
          p_load  = 1'b1;
        end else begin
          p_load     = 1'b1;
          next_state = FIRE;
        end
      end
      DRAIN: begin
        if (!SEQ_BUSY) begin
          done_next  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state       <= IDLE;
      SEQ_START   <= 1'b0;
      AMP_EN      <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      CONV_CNT    <= '0;
      OVERRUN_CNT <= '0;
      num_sh      <= '0;
      per_sh      <= '0;
    end else begin
      state     <= next_state;
      SEQ_START <= (next_state == FIRE);
      AMP_EN    <= (next_state != IDLE);
      BUSY      <= (next_state != IDLE);
      DONE      <= done_next;
      if (accept) begin
        num_sh      <= CFG_NUM_CONV;
        per_sh      <= CFG_PERIOD;
        CONV_CNT    <= '0;
        OVERRUN_CNT <= '0;
      end else begin
        if (next_state == FIRE) begin
          CONV_CNT <= CONV_CNT + ONE;
        end
        if (ovr_hit && OVERRUN_CNT != '1) begin
          OVERRUN_CNT <= OVERRUN_CNT + ONE;
        end
      end
    end
  end

endmodule
